// File: rtl/mem_stage_lsu_pkg.sv
// Shared types for the MEM-stage load/store unit.
// Holds the FSM states, funct3 codes, and the legality, byte-enable and write-data helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RD,
    S_DONE
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic lsu_legal(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~st;
      F3_HU:   ok = ~st & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lsu_be(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (1'b1)
      (f3[1:0] == 2'b00): be = 4'b0001 << off;
      (f3[1:0] == 2'b01): be = off[1] ? 4'b1100 : 4'b0011;
      default:            be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lsu_wdata(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] w;
    w = d;
    unique case (1'b1)
      (f3[1:0] == 2'b00): w = {4{d[7:0]}};
      (f3[1:0] == 2'b01): w = {2{d[15:0]}};
      default:            w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/response bus between the LSU and memory.
// master = LSU side, slave = memory side.
interface mem_stage_lsu_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_be_o,
    output dmem_wdata_o,
    input  dmem_gnt_i,
    input  dmem_rvalid_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_be_o,
    input  dmem_wdata_o,
    output dmem_gnt_i,
    output dmem_rvalid_i,
    output dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: shift the addressed lane down,
// then sign- or zero-extend by funct3.
module load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [31:0] sh;

  always_comb begin
    sh   = rdata >> {byte_off, 3'b000};
    data = sh;
    unique case (1'b1)
      (funct3 == F3_B):  data = {{24{sh[7]}}, sh[7:0]};
      (funct3 == F3_H):  data = {{16{sh[15]}}, sh[15:0]};
      (funct3 == F3_BU): data = {24'd0, sh[7:0]};
      (funct3 == F3_HU): data = {16'd0, sh[15:0]};
      default:           data = sh;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding data-memory access,
// stalling the pipeline until the store is granted or the load returns.
module mem_stage_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        access_valid_i,
  input  logic        memRW_i,
  input  logic [2:0]  ld_st_sel_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] dataR2_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        load_valid_o,
  output logic        access_err_o,
  mem_stage_lsu_if.master dmem
);

  lsu_state_e  state;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        req_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] load_data_q;
  logic        load_valid_q;
  logic        legal;
  logic        start;
  logic [31:0] align_data;

  assign legal = lsu_legal(memRW_i, ld_st_sel_i, alu_out_i[1:0]);
  assign start = (state == S_IDLE) && access_valid_i && legal;

  assign access_err_o = (state == S_IDLE) && access_valid_i && !legal;
  assign stall_o      = start || (state == S_REQ) || (state == S_WAIT_RD);

  assign load_data_o  = load_data_q;
  assign load_valid_o = load_valid_q;

  assign dmem.dmem_req_o   = req_q;
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_be_o    = be_q;
  assign dmem.dmem_wdata_o = wdata_q;

  load_align u_align (
    .funct3   (f3_q),
    .byte_off (off_q),
    .rdata    (dmem.dmem_rdata_i),
    .data     (align_data)
  );

  // Request fields are latched at issue so the bus stays stable while waiting for gnt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      req_q        <= 1'b0;
      addr_q       <= 32'd0;
      be_q         <= 4'd0;
      wdata_q      <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
    end else begin
      load_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            we_q    <= memRW_i;
            f3_q    <= ld_st_sel_i;
            off_q   <= alu_out_i[1:0];
            addr_q  <= {alu_out_i[31:2], 2'b00};
            be_q    <= lsu_be(ld_st_sel_i, alu_out_i[1:0]);
            wdata_q <= lsu_wdata(ld_st_sel_i, dataR2_i);
            req_q   <= 1'b1;
            state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (dmem.dmem_gnt_i) begin
            req_q <= 1'b0;
            state <= we_q ? S_DONE : S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          if (dmem.dmem_rvalid_i) begin
            load_data_q  <= align_data;
            load_valid_q <= 1'b1;
            state        <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
